// File: rtl/tl_d_resp_queue.sv
// TileLink-UL D-channel response queue (1 or 2 entries) with A-request outstanding tracking.
// Latency 1 cycle enq->deq, no combinational enq->deq path; enq_ready = not full or deq_ready.
module tl_d_resp_queue #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DATA_W          = 32,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_fire,
  output logic              a_ready_gate,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [2:0]        enq_opcode,
  input  logic [1:0]        enq_param,
  input  logic [3:0]        enq_size,
  input  logic [3:0]        enq_source,
  input  logic              enq_denied,
  input  logic              enq_corrupt,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [2:0]        deq_opcode,
  output logic [1:0]        deq_param,
  output logic [3:0]        deq_size,
  output logic [3:0]        deq_source,
  output logic              deq_denied,
  output logic              deq_corrupt,
  output logic [DATA_W-1:0] deq_data,
  output logic [1:0]        count,
  output logic [OUT_W-1:0]  outstanding,
  output logic              err_unexpected_d
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [3:0]        size;
    logic [3:0]        source;
    logic              denied;
    logic              corrupt;
    logic [DATA_W-1:0] data;
  } d_entry_t;

  localparam logic [1:0]       DEPTH_C  = 2'(DEPTH);
  localparam logic             PTR_LAST = 1'(DEPTH - 1);
  localparam logic [OUT_W-1:0] MAX_C    = OUT_W'(MAX_OUTSTANDING);

  d_entry_t         mem [DEPTH];
  d_entry_t         enq_entry;
  d_entry_t         head;
  logic             wptr_q, rptr_q;
  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q;
  logic             enq_fire, deq_fire, a_take;

  assign enq_entry = '{opcode: enq_opcode, param: enq_param, size: enq_size,
                       source: enq_source, denied: enq_denied, corrupt: enq_corrupt,
                       data: enq_data};

  assign deq_valid    = (count_q != 2'd0);
  assign enq_ready    = (count_q < DEPTH_C) | deq_ready;
  assign enq_fire     = enq_valid & enq_ready;
  assign deq_fire     = deq_valid & deq_ready;
  assign a_ready_gate = (out_q < MAX_C);
  // Requests arriving while saturated are an upstream bug and are not counted.
  assign a_take       = a_fire & (out_q != MAX_C);

  always_comb begin
    count_d = count_q;
    if (enq_fire && !deq_fire)      count_d = count_q + 2'd1;
    else if (deq_fire && !enq_fire) count_d = count_q - 2'd1;
  end

  always_comb begin
    out_d = out_q;
    if (a_take && !enq_fire)                         out_d = out_q + 1'b1;
    else if (enq_fire && !a_take && out_q != '0)     out_d = out_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (enq_fire) wptr_q <= (wptr_q == PTR_LAST) ? 1'b0 : wptr_q + 1'b1;
      if (deq_fire) rptr_q <= (rptr_q == PTR_LAST) ? 1'b0 : rptr_q + 1'b1;
      count_q <= count_d;
      out_q   <= out_d;
      if (enq_fire && out_q == '0 && !a_fire) err_q <= 1'b1;
    end
  end

  // When full with a dequeue, wptr==rptr: the head is read before the edge overwrites it.
  always_ff @(posedge clock) begin
    if (enq_fire) mem[wptr_q] <= enq_entry;
  end

  assign head             = mem[rptr_q];
  assign deq_opcode       = head.opcode;
  assign deq_param        = head.param;
  assign deq_size         = head.size;
  assign deq_source       = head.source;
  assign deq_denied       = head.denied;
  assign deq_corrupt      = head.corrupt;
  assign deq_data         = head.data;
  assign count            = count_q;
  assign outstanding      = out_q;
  assign err_unexpected_d = err_q;

endmodule

// File: tb/tb_tl_d_resp_queue.sv
// Directed bench for tl_d_resp_queue; accepted enqueues feed a scoreboard checked by a dequeue monitor.
module tb_tl_d_resp_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_fire;
  logic        a_ready_gate;
  logic        enq_valid, enq_ready;
  logic [2:0]  enq_opcode;
  logic [1:0]  enq_param;
  logic [3:0]  enq_size, enq_source;
  logic        enq_denied, enq_corrupt;
  logic [31:0] enq_data;
  logic        deq_valid, deq_ready;
  logic [2:0]  deq_opcode;
  logic [1:0]  deq_param;
  logic [3:0]  deq_size, deq_source;
  logic        deq_denied, deq_corrupt;
  logic [31:0] deq_data;
  logic [1:0]  count;
  logic [3:0]  outstanding;
  logic        err_unexpected_d;

  int n_checks = 0;
  int n_fail   = 0;
  logic [46:0] sb [$];
  logic [46:0] exp_e;

  always #5 clock = ~clock;

  tl_d_resp_queue #(.DEPTH(2), .MAX_OUTSTANDING(8), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .a_fire(a_fire), .a_ready_gate(a_ready_gate),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_opcode(enq_opcode),
    .enq_param(enq_param), .enq_size(enq_size), .enq_source(enq_source),
    .enq_denied(enq_denied), .enq_corrupt(enq_corrupt), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_opcode(deq_opcode),
    .deq_param(deq_param), .deq_size(deq_size), .deq_source(deq_source),
    .deq_denied(deq_denied), .deq_corrupt(deq_corrupt), .deq_data(deq_data),
    .count(count), .outstanding(outstanding), .err_unexpected_d(err_unexpected_d)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [3:0] src, input logic [31:0] data);
    enq_valid   = 1'b1;
    enq_opcode  = op;
    enq_param   = src[1:0];
    enq_size    = 4'd2;
    enq_source  = src;
    enq_denied  = src[2];
    enq_corrupt = src[3];
    enq_data    = data;
  endtask

  // Holds enq_valid until accepted; returns at posedge+1 with enq_valid still high.
  task automatic do_enq(input logic [2:0] op, input logic [3:0] src, input logic [31:0] data);
    logic r;
    bit   done = 0;
    set_fields(op, src, data);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      r = enq_ready;
      @(posedge clock);
      if (r) begin
        sb.push_back({op, src[1:0], 4'd2, src, src[2], src[3], data});
        done = 1;
      end
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL enq_timeout: source %0d not accepted within 20 cycles", src);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && deq_valid === 1'b1 && deq_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL deq_unexpected: got source %0d, expected no output", deq_source);
      end else begin
        exp_e = sb.pop_front();
        chk("deq_entry", {17'd0, deq_opcode, deq_param, deq_size, deq_source,
                          deq_denied, deq_corrupt, deq_data}, {17'd0, exp_e});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; a_fire = 1'b0; deq_ready = 1'b0; enq_valid = 1'b0;
    enq_opcode = '0; enq_param = '0; enq_size = '0; enq_source = '0;
    enq_denied = 1'b0; enq_corrupt = 1'b0; enq_data = '0;
    step(); step();
    @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_err", err_unexpected_d, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_a_ready_gate", a_ready_gate, 1);
    step();
    reset_n = 1'b1;

    // Single transaction, 1-cycle latency
    a_fire = 1'b1; step(); a_fire = 1'b0;
    @(negedge clock);
    chk("t1_outstanding_1", outstanding, 1);
    chk("t1_deq_valid_idle", deq_valid, 0);
    step();
    deq_ready = 1'b1;
    do_enq(3'd1, 4'd3, 32'hDEAD_BEEF);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t1_deq_valid_next", deq_valid, 1);
    chk("t1_outstanding_0", outstanding, 0);
    chk("t1_count_1", count, 1);
    step();
    @(negedge clock);
    chk("t1_count_0", count, 0);
    chk("t1_deq_valid_0", deq_valid, 0);
    step();

    // Backpressure: fill, third held off, released in order
    deq_ready = 1'b0;
    a_fire = 1'b1; repeat (3) step(); a_fire = 1'b0;
    do_enq(3'd1, 4'd1, 32'h1111_1111);
    do_enq(3'd1, 4'd2, 32'h2222_2222);
    set_fields(3'd1, 4'd3, 32'h3333_3333);
    @(negedge clock);
    chk("t2_enq_ready_full", enq_ready, 0);
    chk("t2_count_2", count, 2);
    chk("t2_head_source", deq_source, 1);
    chk("t2_head_data", deq_data, 32'h1111_1111);
    chk("t2_outstanding_1", outstanding, 1);
    step();
    @(negedge clock);
    chk("t2_head_hold", deq_source, 1);
    chk("t2_outstanding_hold", outstanding, 1);
    step();
    deq_ready = 1'b1;
    do_enq(3'd1, 4'd3, 32'h3333_3333);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t2_count_still_2", count, 2);
    chk("t2_outstanding_0", outstanding, 0);
    step(); step();
    @(negedge clock);
    chk("t2_drained", count, 0);
    step();

    // Streaming through a full queue with pointer wrap
    deq_ready = 1'b0;
    a_fire = 1'b1; repeat (8) step(); a_fire = 1'b0;
    do_enq(3'd1, 4'd10, 32'hA0A0_A0A0);
    do_enq(3'd1, 4'd11, 32'hB0B0_B0B0);
    deq_ready = 1'b1;
    for (int i = 0; i < 6; i++) do_enq(3'd1, 4'(i), 32'h5000_0000 + i);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t3_count_2", count, 2);
    chk("t3_outstanding_0", outstanding, 0);
    step(); step();
    @(negedge clock);
    chk("t3_drained", count, 0);
    step();

    // Unexpected-response detection
    a_fire = 1'b1;
    do_enq(3'd0, 4'd8, 32'h0000_0000);
    a_fire = 1'b0; enq_valid = 1'b0;
    @(negedge clock);
    chk("t4_no_err_same_cycle", err_unexpected_d, 0);
    chk("t4_outstanding_0", outstanding, 0);
    step();
    do_enq(3'd1, 4'd7, 32'h7777_7777);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t4_err_set", err_unexpected_d, 1);
    step(); step(); step();
    @(negedge clock);
    chk("t4_err_sticky", err_unexpected_d, 1);
    step();

    // Outstanding saturation
    a_fire = 1'b1; repeat (8) step(); a_fire = 1'b0;
    @(negedge clock);
    chk("t5_outstanding_8", outstanding, 8);
    chk("t5_gate_low", a_ready_gate, 0);
    step();
    a_fire = 1'b1; step(); a_fire = 1'b0;
    @(negedge clock);
    chk("t5_ninth_ignored", outstanding, 8);
    step();
    do_enq(3'd1, 4'd9, 32'h9999_9999);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t5_outstanding_7", outstanding, 7);
    chk("t5_gate_high", a_ready_gate, 1);
    step(); step();

    // Reset with queued entries
    do_enq(3'd1, 4'd12, 32'hC0C0_C0C0);
    do_enq(3'd1, 4'd13, 32'hD0D0_D0D0);
    enq_valid = 1'b0;
    step();
    deq_ready = 1'b0;
    do_enq(3'd1, 4'd14, 32'hE0E0_E0E0);
    do_enq(3'd1, 4'd15, 32'hF0F0_F0F0);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t6_pre_count", count, 2);
    chk("t6_pre_outstanding", outstanding, 3);
    chk("t6_pre_head", deq_source, 14);
    step();
    reset_n = 1'b0;
    step();
    sb.delete();
    reset_n = 1'b1;
    @(negedge clock);
    chk("t6_count_0", count, 0);
    chk("t6_deq_valid_0", deq_valid, 0);
    chk("t6_outstanding_0", outstanding, 0);
    chk("t6_err_cleared", err_unexpected_d, 0);
    chk("t6_enq_ready", enq_ready, 1);
    step();
    a_fire = 1'b1; step(); a_fire = 1'b0;
    deq_ready = 1'b1;
    do_enq(3'd1, 4'd6, 32'hCAFE_F00D);
    enq_valid = 1'b0;
    @(negedge clock);
    chk("t6_post_deq_valid", deq_valid, 1);
    chk("t6_post_outstanding", outstanding, 0);
    step();
    @(negedge clock);
    chk("t6_post_count", count, 0);
    chk("t6_post_err", err_unexpected_d, 0);
    step(); step();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
